dram_queued: RTL

DRAM_QUEUED -- requirements
Module: dram_queued

---
 rtl/dram_queued.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/dram_queued.sv
// rtl/dram_queued.sv - queued byte-addressed DRAM model with fixed read/write access latency
// Optional range check on request addresses: DRAM_QUEUED_BOUNDS_CHECK_EN
module dram_queued #(
    parameter int DATA_BYTES = 8,
    parameter int MEM_BYTES  = 65536,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LAT     = 3,
    parameter int WR_LAT     = 2,
    parameter int SRC_W      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [1:0]              req_type,
    input  logic [63:0]             req_addr,
    input  logic [8*DATA_BYTES-1:0] req_data,
    input  logic [DATA_BYTES-1:0]   req_be,
    input  logic [SRC_W-1:0]        req_src,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [8*DATA_BYTES-1:0] rsp_data,
    output logic [SRC_W-1:0]        rsp_src,
    output logic                    rsp_err,
    output logic                    busy
);
    localparam int DW     = 8 * DATA_BYTES;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int MW     = $clog2(MEM_BYTES);
    localparam int EW     = 2 + 64 + DW + DATA_BYTES + SRC_W;
    localparam int MAXLAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CW     = $clog2(MAXLAT + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [7:0]            r_mem [MEM_BYTES];
    logic [EW-1:0]         r_fifo [FIFO_DEPTH];
    logic [AW:0]           r_wptr;
    logic [AW:0]           r_rptr;
    logic [1:0]            r_state;
    logic [CW-1:0]         r_cnt;
    logic [MW-1:0]         r_addr;
    logic [DW-1:0]         r_data;
    logic [DATA_BYTES-1:0] r_be;
    logic                  r_wr;
    logic [DW-1:0]         r_rsp_data;
    logic [SRC_W-1:0]      r_rsp_src;
    logic                  r_rsp_err;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_commit;
    logic                  w_oob;
    logic [1:0]            w_h_type;
    logic [63:0]           w_h_addr;
    logic [DW-1:0]         w_h_data;
    logic [DATA_BYTES-1:0] w_h_be;
    logic [SRC_W-1:0]      w_h_src;
    logic [DW-1:0]         w_rd_data;

    // Extra pointer MSB tells a full queue from an empty one when the indices match
    assign w_empty  = (r_wptr == r_rptr);
    assign w_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_push   = req_valid && !w_full;
    assign w_pop    = (r_state == S_IDLE) && !w_empty;
    assign w_commit = (r_state == S_ACCESS) && (r_cnt == '0) && r_wr;

    assign {w_h_type, w_h_addr, w_h_data, w_h_be, w_h_src} = r_fifo[r_rptr[AW-1:0]];

`ifdef DRAM_QUEUED_BOUNDS_CHECK_EN
    assign w_oob = ({1'b0, w_h_addr} + 65'(DATA_BYTES)) > 65'(MEM_BYTES);
`else
    logic w_unused_addr_hi;
    assign w_oob            = 1'b0;
    assign w_unused_addr_hi = ^w_h_addr[63:MW];
`endif

    assign req_ready = !w_full;
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_data  = r_rsp_data;
    assign rsp_src   = r_rsp_src;
    assign rsp_err   = r_rsp_err;
    assign busy      = !w_empty || (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wptr[AW-1:0]] <= {req_type, req_addr, req_data, req_be, req_src};
        end
    end

    // Byte index arithmetic is MW bits wide, so accesses wrap at MEM_BYTES
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            w_rd_data[8*i +: 8] = r_mem[r_addr + MW'(i)];
        end
    end

    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int i = 0; i < DATA_BYTES; i++) begin
                if (r_be[i]) begin
                    r_mem[r_addr + MW'(i)] <= r_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_be       <= '0;
            r_wr       <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_src  <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_addr    <= w_h_addr[MW-1:0];
                        r_data    <= w_h_data;
                        r_be      <= w_h_be;
                        r_wr      <= (w_h_type == 2'd1);
                        r_rsp_src <= w_h_src;
                        if (w_h_type[1] || w_oob) begin
                            r_rsp_err  <= 1'b1;
                            r_rsp_data <= '0;
                            r_state    <= S_RESP;
                        end else begin
                            r_rsp_err <= 1'b0;
                            r_cnt     <= (w_h_type == 2'd0) ? CW'(RD_LAT) : CW'(WR_LAT);
                            r_state   <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    if (r_cnt == '0) begin
                        if (r_wr) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_rsp_data <= w_rd_data;
                            r_state    <= S_RESP;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
